// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: turns a change amount into timed 10/5/2/1 hopper eject pulses.
// Optional per-denomination stock tracking is enabled with `define COIN_INVENTORY_EN.
module change_dispenser #(
    parameter int WIDTH        = 7,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter int INIT_COUNT   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_amount,
    input  logic             i_reload,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_eject10,
    output logic             o_eject5,
    output logic             o_eject2,
    output logic             o_eject1,
    output logic [WIDTH-1:0] o_remaining,
    output logic [3:0]       o_coin_count,
    output logic             o_short
);
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_rem;
    logic [3:0]       r_cnt;
    logic [3:0]       r_sel;      // one-hot {10,5,2,1} of the coin being ejected
    logic [TW-1:0]    r_tmr;
    logic [3:0]       w_ok;
    logic [3:0]       w_pick;
    logic [WIDTH-1:0] w_val;
    logic             w_none;
    logic             w_take;
    logic             w_pulse_end;
    logic             w_gap_end;

`ifdef COIN_INVENTORY_EN
    logic [3:0] r_stock [4];
    logic       r_short;
`else
    logic       w_unused_reload;
    assign w_unused_reload = i_reload;
`endif

    always_comb begin
        w_ok[3] = (r_rem >= WIDTH'(10));
        w_ok[2] = (r_rem >= WIDTH'(5));
        w_ok[1] = (r_rem >= WIDTH'(2));
        w_ok[0] = (r_rem >= WIDTH'(1));
`ifdef COIN_INVENTORY_EN
        for (int i = 0; i < 4; i++)
            if (r_stock[i] == 4'd0) w_ok[i] = 1'b0;
`endif
    end

    always_comb begin
        w_pick = 4'b0000;
        w_val  = '0;
        if (w_ok[3])      begin w_pick = 4'b1000; w_val = WIDTH'(10); end
        else if (w_ok[2]) begin w_pick = 4'b0100; w_val = WIDTH'(5);  end
        else if (w_ok[1]) begin w_pick = 4'b0010; w_val = WIDTH'(2);  end
        else if (w_ok[0]) begin w_pick = 4'b0001; w_val = WIDTH'(1);  end
    end

    assign w_none      = (w_pick == 4'b0000);
    assign w_take      = (r_state == S_SELECT) && (r_rem != '0) && !w_none;
    assign w_pulse_end = (r_tmr == TW'(PULSE_CYCLES - 1));
    assign w_gap_end   = (r_tmr == TW'(GAP_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_SELECT;
            S_SELECT: w_next = w_take ? S_PULSE : S_DONE;
            S_PULSE:  if (w_pulse_end) w_next = S_GAP;
            S_GAP:    if (w_gap_end) w_next = S_SELECT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem <= '0;
            r_cnt <= '0;
            r_sel <= '0;
            r_tmr <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_rem <= i_amount;
                    r_cnt <= '0;
                end
                S_SELECT: begin
                    r_tmr <= '0;
                    if (w_take) begin
                        r_sel <= w_pick;
                        r_rem <= r_rem - w_val;
                        if (r_cnt != 4'd15) r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_PULSE: r_tmr <= w_pulse_end ? '0 : r_tmr + TW'(1);
                S_GAP:   r_tmr <= w_gap_end   ? '0 : r_tmr + TW'(1);
                default: ;
            endcase
        end
    end

`ifdef COIN_INVENTORY_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state == S_IDLE && i_reload)) begin
            for (int i = 0; i < 4; i++) r_stock[i] <= 4'(INIT_COUNT);
        end else if (w_take) begin
            for (int i = 0; i < 4; i++)
                if (w_pick[i]) r_stock[i] <= r_stock[i] - 4'd1;
        end
    end

    // short flags a job that ran out of usable coins with value still owed
    always_ff @(posedge i_clk) begin
        if (i_rst)                               r_short <= 1'b0;
        else if (r_state == S_IDLE && i_start)   r_short <= 1'b0;
        else if (r_state == S_SELECT && r_rem != '0 && w_none) r_short <= 1'b1;
    end
    assign o_short = r_short;
`else
    assign o_short = 1'b0;
`endif

    assign o_busy       = (r_state == S_SELECT) || (r_state == S_PULSE) || (r_state == S_GAP);
    assign o_done       = (r_state == S_DONE);
    assign o_eject10    = (r_state == S_PULSE) && r_sel[3];
    assign o_eject5     = (r_state == S_PULSE) && r_sel[2];
    assign o_eject2     = (r_state == S_PULSE) && r_sel[1];
    assign o_eject1     = (r_state == S_PULSE) && r_sel[0];
    assign o_remaining  = r_rem;
    assign o_coin_count = r_cnt;
endmodule
